conv1d_window: RTL and testbench

- Upstream producer for the neuron: turns a scalar sample stream into KERNEL_SIZE-wide sliding windows.
- Drives the neuron's valid/data inputs and honours its ready, using the same valid/ready stream protocol.
- Frames are delimited by a last flag. Windows never span a frame boundary.
- Supports a configurable stride for 1D convolution layers.

---
 rtl/conv1d_window.sv | 132 +++++++++++++
 tb/tb_conv1d_window.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_window.sv
// Sliding-window front end for the 1D neuron.
// Turns a scalar valid/ready sample stream into KERNEL_SIZE-wide windows,
// with a configurable stride. Windows never span a frame boundary.
// A frame that ends without producing its final window raises frame_err
// for one cycle.

package cnn1d_pkg;
  parameter int DATA_WIDTH = 8;
endpackage

module conv1d_window #(
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int DATA_WIDTH  = cnn1d_pkg::DATA_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  output logic                                   sample_ready_in,
  input  logic                                   sample_valid_in,
  input  logic [DATA_WIDTH-1:0]                  sample_data_in,
  input  logic                                   sample_last_in,
  input  logic                                   win_ready_out,
  output logic                                   win_valid_out,
  output logic [0:KERNEL_SIZE-1][DATA_WIDTH-1:0] win_data_out,
  output logic                                   win_last_out,
  output logic                                   frame_err
);

  // Fill counter saturates at KERNEL_SIZE; stride phase counts 0..STRIDE-1.
  localparam int FW = $clog2(KERNEL_SIZE + 1);
  localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  logic [0:KERNEL_SIZE-1][DATA_WIDTH-1:0] shift_q, shift_next;
  logic [FW-1:0]                          fill_q, fill_next;
  logic [SW-1:0]                          stride_q, stride_next;

  logic sample_acc;
  logic win_acc;
  logic fill_full;
  logic emit;
  logic drop_err;

  // The output register can take a new window when empty or being drained;
  // nothing is accepted while reset is held.
  assign sample_ready_in = rst & (~win_valid_out | win_ready_out);
  assign sample_acc      = sample_valid_in & sample_ready_in;
  assign win_acc         = win_valid_out & win_ready_out;

  // Next shift-register contents, fill/stride bookkeeping and emit decision.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    shift_next  = shift_q;
    fill_next   = fill_q;
    stride_next = stride_q;
    emit        = 1'b0;
    drop_err    = 1'b0;

    fill_full = (fill_q == FW'(KERNEL_SIZE));

    for (int i = 0; i < KERNEL_SIZE - 1; i++) begin
      shift_next[i] = shift_q[i+1];
    end
    shift_next[KERNEL_SIZE-1] = sample_data_in;

    if (sample_acc) begin
      if (fill_full) begin
        // Steady state: emit once every STRIDE samples.
        if (stride_q == SW'(STRIDE - 1)) begin
          emit        = 1'b1;
          stride_next = '0;
        end else begin
          stride_next = stride_q + SW'(1);
        end
      end else begin
        // Filling: the KERNEL_SIZE-th sample completes the first window.
        fill_next   = fill_q + FW'(1);
        stride_next = '0;
        emit        = (fill_q == FW'(KERNEL_SIZE - 1));
      end

      // A frame's last sample restarts the fill; a tail that did not
      // complete a window is dropped and flagged.
      if (sample_last_in) begin
        fill_next   = '0;
        stride_next = '0;
        drop_err    = ~emit;
      end
    end
  end

  // Sample history and fill/stride counters advance only on accepted samples.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      shift_q  <= '0;
      fill_q   <= '0;
      stride_q <= '0;
    end else if (sample_acc) begin
      shift_q  <= shift_next;
      fill_q   <= fill_next;
      stride_q <= stride_next;
    end
  end

  // Output window register: load on emit, clear when drained, else hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_valid_out <= 1'b0;
      win_last_out  <= 1'b0;
      win_data_out  <= '0;
    end else if (emit) begin
      win_valid_out <= 1'b1;
      win_last_out  <= sample_last_in;
      win_data_out  <= shift_next;
    end else if (win_acc) begin
      win_valid_out <= 1'b0;
      win_last_out  <= 1'b0;
    end
  end

  // One-cycle pulse when a frame's last sample produced no window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= drop_err;
    end
  end

endmodule

// File: tb/tb_conv1d_window.sv
// Bench for conv1d_window: two instances (STRIDE=1 and STRIDE=2, both
// KERNEL_SIZE=3) share clock and reset. A frame model predicts windows and
// frame errors at sample acceptance; monitors compare them with DUT output.

module tb_conv1d_window;

  localparam int K  = 3;
  localparam int DW = cnn1d_pkg::DATA_WIDTH;

  typedef logic [0:K-1][DW-1:0] win_data_t;
  typedef struct {
    win_data_t data;
    logic      last;
  } win_t;

  logic            clk;
  logic            rst;
  logic            s_ready [2];
  logic            s_valid [2];
  logic [DW-1:0]   s_data  [2];
  logic            s_last  [2];
  logic            w_ready [2];
  logic            w_valid [2];
  win_data_t       w_data  [2];
  logic            w_last  [2];
  logic            f_err   [2];

  int checks = 0;
  int errors = 0;

  // Scoreboard and frame model, one per instance.
  win_t          exp_q [2][$];
  logic [DW-1:0] frm_q [2][$];

  // Expectations for the cycle after an accepted sample.
  logic pend     [2];
  logic pend_emit[2];
  logic pend_err [2];
  int   err_seen [2];

  conv1d_window #(.KERNEL_SIZE(K), .STRIDE(1)) u_s1 (
    .clk(clk), .rst(rst),
    .sample_ready_in(s_ready[0]), .sample_valid_in(s_valid[0]),
    .sample_data_in(s_data[0]),   .sample_last_in(s_last[0]),
    .win_ready_out(w_ready[0]),   .win_valid_out(w_valid[0]),
    .win_data_out(w_data[0]),     .win_last_out(w_last[0]),
    .frame_err(f_err[0])
  );

  conv1d_window #(.KERNEL_SIZE(K), .STRIDE(2)) u_s2 (
    .clk(clk), .rst(rst),
    .sample_ready_in(s_ready[1]), .sample_valid_in(s_valid[1]),
    .sample_data_in(s_data[1]),   .sample_last_in(s_last[1]),
    .win_ready_out(w_ready[1]),   .win_valid_out(w_valid[1]),
    .win_data_out(w_data[1]),     .win_last_out(w_last[1]),
    .frame_err(f_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Window scoreboard: a window accepted at the coming edge must match the
  // oldest prediction.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst && w_valid[i] && w_ready[i]) begin
        checks++;
        if (exp_q[i].size() == 0) begin
          errors++;
          $display("FAIL win_unexpected dut%0d: got data=%h last=%b, expected no window",
                   i, w_data[i], w_last[i]);
        end else begin
          win_t e;
          e = exp_q[i].pop_front();
          if (w_data[i] !== e.data || w_last[i] !== e.last) begin
            errors++;
            $display("FAIL win_data dut%0d: got data=%h last=%b, expected data=%h last=%b",
                     i, w_data[i], w_last[i], e.data, e.last);
          end
        end
      end
    end
  end

  // Latency and frame_err monitor, sampled just after the active edge.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        if (f_err[i]) err_seen[i]++;
        if (pend[i] && pend_emit[i]) begin
          checks++;
          if (w_valid[i] !== 1'b1) begin
            errors++;
            $display("FAIL win_latency dut%0d: got valid=%b, expected 1", i, w_valid[i]);
          end
        end
        checks++;
        if (f_err[i] !== (pend[i] & pend_err[i])) begin
          errors++;
          $display("FAIL frame_err dut%0d: got %b, expected %b",
                   i, f_err[i], pend[i] & pend_err[i]);
        end
      end
      pend[i] = 1'b0;
    end
  end

  // Frame model: window when the frame holds >= K samples and the count past
  // K is a multiple of the stride; a last sample without a window is an error.
  task automatic model_accept(input int sel, input logic [DW-1:0] d, input logic last);
    int   n;
    int   stride;
    logic emit;
    win_t w;
    stride = (sel == 0) ? 1 : 2;
    frm_q[sel].push_back(d);
    n    = frm_q[sel].size();
    emit = (n >= K) && (((n - K) % stride) == 0);
    if (emit) begin
      for (int j = 0; j < K; j++) w.data[j] = frm_q[sel][n - K + j];
      w.last = last;
      exp_q[sel].push_back(w);
    end
    pend_emit[sel] = emit;
    pend_err[sel]  = last & ~emit;
    pend[sel]      = 1'b1;
    if (last) frm_q[sel].delete();
  endtask

  // Offer one sample; called just after a rising edge, returns just after the
  // edge that accepted it. stalls reports cycles spent waiting on ready.
  task automatic send_sample(input int sel, input logic [DW-1:0] d, input logic last,
                             output int stalls);
    stalls = 0;
    s_valid[sel] = 1'b1;
    s_data[sel]  = d;
    s_last[sel]  = last;
    forever begin
      @(negedge clk);
      if (s_ready[sel]) begin
        model_accept(sel, d, last);
        break;
      end
      stalls++;
      if (stalls > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout dut%0d: sample %0d not accepted in 50 cycles", sel, d);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid[sel] = 1'b0;
    s_last[sel]  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_queues_empty(input string tag);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL %s_missing dut%0d: got %0d windows outstanding, expected 0",
                 tag, i, exp_q[i].size());
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (w_valid[i] !== 1'b0 || w_last[i] !== 1'b0 || f_err[i] !== 1'b0 ||
          w_data[i] !== '0 || s_ready[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got valid=%b last=%b err=%b data=%h ready=%b, expected all 0",
                 i, w_valid[i], w_last[i], f_err[i], w_data[i], s_ready[i]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (s_ready[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_release_ready dut%0d: got %b, expected 1", i, s_ready[i]);
      end
    end
  endtask

  task automatic test_stride1();
    int st;
    int total;
    total = 0;
    for (int v = 1; v <= 5; v++) begin
      send_sample(0, DW'(v), v == 5, st);
      total += st;
    end
    checks++;
    if (total != 0) begin
      errors++;
      $display("FAIL stride1_ready: got %0d stall cycles, expected 0", total);
    end
    idle(2);
    check_queues_empty("stride1");
  endtask

  task automatic test_stride2();
    int st;
    int err_before;
    err_before = err_seen[1];
    for (int v = 1; v <= 7; v++) send_sample(1, DW'(v), v == 7, st);
    idle(2);
    checks++;
    if (err_seen[1] != err_before) begin
      errors++;
      $display("FAIL stride2_no_err: got %0d frame_err pulses, expected 0",
               err_seen[1] - err_before);
    end
    check_queues_empty("stride2");
  endtask

  task automatic test_backpressure();
    int st;
    w_ready[0] = 1'b0;
    for (int v = 1; v <= 3; v++) send_sample(0, DW'(v), 1'b0, st);
    fork
      send_sample(0, DW'(4), 1'b1, st);
      begin
        win_data_t held;
        held = {DW'(1), DW'(2), DW'(3)};
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (w_valid[0] !== 1'b1 || w_data[0] !== held || s_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold: got valid=%b data=%h ready=%b, expected 1 %h 0",
                     w_valid[0], w_data[0], s_ready[0], held);
          end
        end
        @(posedge clk);
        #1;
        w_ready[0] = 1'b1;
      end
    join
    checks++;
    if (st != 5) begin
      errors++;
      $display("FAIL backpressure_stalls: got %0d stall cycles, expected 5", st);
    end
    idle(2);
    check_queues_empty("backpressure");
  endtask

  task automatic test_short_frame();
    int st;
    int err_before;
    err_before = err_seen[0];
    send_sample(0, DW'(7), 1'b0, st);
    send_sample(0, DW'(8), 1'b1, st);
    idle(2);
    checks++;
    if (err_seen[0] != err_before + 1) begin
      errors++;
      $display("FAIL short_frame_err: got %0d pulse cycles, expected 1", err_seen[0] - err_before);
    end
    send_sample(0, DW'(10), 1'b0, st);
    send_sample(0, DW'(11), 1'b0, st);
    send_sample(0, DW'(12), 1'b1, st);
    idle(2);
    check_queues_empty("short_frame");
  endtask

  task automatic test_stride_tail();
    int st;
    int err_before;
    err_before = err_seen[1];
    for (int v = 1; v <= 4; v++) send_sample(1, DW'(v), v == 4, st);
    idle(2);
    checks++;
    if (err_seen[1] != err_before + 1) begin
      errors++;
      $display("FAIL stride_tail_err: got %0d pulse cycles, expected 1", err_seen[1] - err_before);
    end
    // Next frame must start from an empty window.
    for (int v = 20; v <= 22; v++) send_sample(1, DW'(v), v == 22, st);
    idle(2);
    check_queues_empty("stride_tail");
  endtask

  task automatic test_reset_mid();
    int st;
    w_ready[0] = 1'b0;
    send_sample(0, DW'(1), 1'b0, st);
    send_sample(0, DW'(2), 1'b0, st);
    send_sample(0, DW'(3), 1'b0, st);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (w_valid[0] !== 1'b0 || w_data[0] !== '0 || w_last[0] !== 1'b0 || s_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got valid=%b data=%h last=%b ready=%b, expected 0 0 0 0",
               w_valid[0], w_data[0], w_last[0], s_ready[0]);
    end
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      frm_q[i].delete();
      pend[i] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    w_ready[0] = 1'b1;
    idle(1);
    for (int v = 5; v <= 7; v++) send_sample(0, DW'(v), v == 7, st);
    idle(2);
    check_queues_empty("reset_mid");
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      s_valid[i]  = 1'b0;
      s_data[i]   = '0;
      s_last[i]   = 1'b0;
      w_ready[i]  = 1'b1;
      pend[i]     = 1'b0;
      pend_emit[i] = 1'b0;
      pend_err[i] = 1'b0;
      err_seen[i] = 0;
    end
    rst = 1'b0;

    test_reset();
    test_stride1();
    test_stride2();
    test_backpressure();
    test_short_frame();
    test_stride_tail();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
